// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between the audio source and the I2S transmitter.
interface i2s_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             valid;
  logic             ready;

  modport master (output left, right, valid, input ready);
  modport slave  (input left, right, valid, output ready);
endinterface

// File: rtl/i2s_tx.sv
// Stereo I2S / left-justified transmitter: one-deep holding register, clock
// generation from clk, MSB-first serialisation with underrun muting.
module i2s_tx #(
  parameter int WIDTH = 16,
  parameter int SLOT  = 16,
  parameter int DIV   = 1
) (
  input  logic    clk,
  input  logic    reset,
  i2s_tx_if.slave bus,
  input  logic    justify,
  output logic    mclk,
  output logic    sclk,
  output logic    lrclk,
  output logic    sdin,
  output logic    underrun
);
  localparam int PW = $clog2(2*SLOT);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST  = PW'(2*SLOT-1);
  localparam logic [PW-1:0] SLOTV = PW'(SLOT);
  localparam logic [CW-1:0] CMAX  = CW'(DIV-1);

  logic [CW-1:0]    cnt;
  logic [PW-1:0]    p;
  logic             mode;
  logic             hold_full;
  logic [WIDTH-1:0] hold_l, hold_r, frame_l, frame_r;

  logic             wrap, shift, load, accept, mode_n, ch, bit_n;
  logic [PW-1:0]    p_n, q, k;
  logic [WIDTH-1:0] word;

  always_comb begin
    wrap   = (cnt == CMAX);
    shift  = wrap && sclk;
    p_n    = (p == LAST) ? '0 : p + PW'(1);
    // the mode sampled at p=0 already governs the bit sent on that edge
    mode_n = (p_n == '0) ? justify : mode;
    if (mode_n)           q = p_n;
    else if (p_n == '0)   q = LAST;
    else                  q = p_n - PW'(1);
    ch     = (q >= SLOTV);
    k      = ch ? q - SLOTV : q;
    load   = shift && (q == '0);
    accept = bus.valid && bus.ready;
    // the load edge emits the first bit of the incoming frame (q=0 is left)
    if (load)    word = hold_full ? hold_l : '0;
    else if (ch) word = frame_r;
    else         word = frame_l;
    bit_n = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (k == PW'(i)) bit_n = word[WIDTH-1-i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mclk      <= 1'b0;
      sclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdin      <= 1'b0;
      underrun  <= 1'b0;
      bus.ready <= 1'b1;
      cnt       <= '0;
      p         <= LAST;
      mode      <= 1'b0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      frame_l   <= '0;
      frame_r   <= '0;
    end else begin
      mclk     <= ~mclk;
      cnt      <= wrap ? '0 : cnt + CW'(1);
      underrun <= load && !hold_full;
      if (wrap) sclk <= ~sclk;
      if (shift) begin
        p     <= p_n;
        mode  <= mode_n;
        lrclk <= (p_n >= SLOTV);
        sdin  <= bit_n;
      end
      if (load) begin
        frame_l   <= hold_full ? hold_l : '0;
        frame_r   <= hold_full ? hold_r : '0;
        hold_full <= 1'b0;
      end
      // no bypass: a pair captured on an underrunning load waits a frame
      if (accept) begin
        hold_l    <= bus.left;
        hold_r    <= bus.right;
        hold_full <= 1'b1;
        bus.ready <= 1'b0;
      end else if (!hold_full) begin
        bus.ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Random and directed checks of two i2s_tx configurations against an
// edge-count reference model.
module tb_i2s_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int W[2] = '{16, 8};
  localparam int S[2] = '{16, 16};
  localparam int D[2] = '{1, 3};

  bit   [1:0]  rst;
  bit          v[2], js[2];
  logic [31:0] li[2], ri[2];
  logic [1:0]  mc, sc, lr, sd, ur, rdy;

  i2s_tx_if #(.WIDTH(16)) ifa ();
  i2s_tx_if #(.WIDTH(8))  ifb ();
  assign ifa.left  = li[0][15:0];
  assign ifa.right = ri[0][15:0];
  assign ifa.valid = v[0];
  assign ifb.left  = li[1][7:0];
  assign ifb.right = ri[1][7:0];
  assign ifb.valid = v[1];
  assign rdy = {ifb.ready, ifa.ready};

  i2s_tx #(.WIDTH(16), .SLOT(16), .DIV(1)) dut_a (
    .clk(clk), .reset(rst[0]), .bus(ifa), .justify(js[0]),
    .mclk(mc[0]), .sclk(sc[0]), .lrclk(lr[0]), .sdin(sd[0]), .underrun(ur[0]));
  i2s_tx #(.WIDTH(8), .SLOT(16), .DIV(3)) dut_b (
    .clk(clk), .reset(rst[1]), .bus(ifb), .justify(js[1]),
    .mclk(mc[1]), .sclk(sc[1]), .lrclk(lr[1]), .sdin(sd[1]), .underrun(ur[1]));

  int n_chk = 0, n_fail = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: outputs derived from edge count n since reset release
  int          n[2], p[2];
  bit          mode[2], hfull[2], e_ready[2], e_lr[2], e_sdin[2], e_ur[2];
  bit          e_shift[2], e_load[2];
  logic [31:0] hl[2], hr[2], fl[2], fr[2];

  function automatic logic [31:0] msk(int d);
    return 32'((64'd1 << W[d]) - 1);
  endfunction

  function automatic bit gb(int d, bit ch, int k);
    logic [31:0] w;
    w = ch ? fr[d] : fl[d];
    if (k < W[d]) return w[W[d]-1-k];
    return 1'b0;
  endfunction

  task automatic mreset(int d);
    n[d] = 0; p[d] = 2*S[d]-1; mode[d] = 0; hfull[d] = 0;
    hl[d] = 0; hr[d] = 0; fl[d] = 0; fr[d] = 0;
    e_ready[d] = 1; e_lr[d] = 0; e_sdin[d] = 0; e_ur[d] = 0;
    e_shift[d] = 0; e_load[d] = 0;
  endtask

  task automatic step(int d);
    bit acc, hf0;
    int q;
    acc = v[d] && e_ready[d];
    hf0 = hfull[d];
    n[d]++;
    e_ur[d] = 0; e_shift[d] = 0; e_load[d] = 0;
    if (n[d] % (2*D[d]) == 0) begin
      e_shift[d] = 1;
      p[d] = (n[d] / (2*D[d]) - 1) % (2*S[d]);
      if (p[d] == 0) mode[d] = js[d];
      q = mode[d] ? p[d] : (p[d] + 2*S[d] - 1) % (2*S[d]);
      if (q == 0) begin
        e_load[d] = 1;
        if (hf0) begin fl[d] = hl[d]; fr[d] = hr[d]; hfull[d] = 0; end
        else begin fl[d] = 0; fr[d] = 0; e_ur[d] = 1; end
      end
      e_lr[d]   = (p[d] >= S[d]);
      e_sdin[d] = gb(d, q >= S[d], q % S[d]);
    end
    if (acc) begin
      hl[d] = li[d]; hr[d] = ri[d]; hfull[d] = 1; e_ready[d] = 0;
    end else if (!hf0) e_ready[d] = 1;
  endtask

  int          phase = 0, ur_cnt = 0;
  logic [31:0] cap0 = 0;
  logic [15:0] cap1 = 0;

  task automatic tick();
    logic [5:0] ev;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) step(d);
      ev = {1'(n[d] % 2), 1'((n[d] / D[d]) % 2), e_lr[d], e_sdin[d], e_ur[d], e_ready[d]};
      chk($sformatf("outs%0d", d), 32'({mc[d], sc[d], lr[d], sd[d], ur[d], rdy[d]}), 32'(ev));
    end
    if (phase == 1 && e_shift[0]) begin
      cap0 = {cap0[30:0], sd[0]};
      if (p[0] == 31) chk("lj_frame", cap0, 32'hA5F00F0F);
    end
    if (phase == 1 && e_shift[1]) begin
      cap1 = {cap1[14:0], sd[1]};
      if (p[1] == 15) chk("pad_left", 32'(cap1), 32'h8100);
    end
    if (phase == 2 && e_shift[0] && p[0] == 0 && mode[0] == 0)
      chk("i2s_p0", 32'(sd[0]), 32'd1);
    if (phase == 3) ur_cnt += int'(ur[0]);
    if (phase == 7 && !rst[1]) begin
      if (n[1] == 3) chk("rst_sclk3", 32'(sc[1]), 32'd1);
      if (n[1] == 6) chk("rst_ur6", 32'(ur[1]), 32'd1);
    end
  endtask

  task automatic wait_load0();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (e_load[0]) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_load timeout");
  endtask

  initial begin
    rst = 2'b11;
    for (int d = 0; d < 2; d++) begin
      v[d] = 0; js[d] = 1; li[d] = 0; ri[d] = 0; mreset(d);
    end
    #2;
    chk("rst_a", 32'({mc[0], sc[0], lr[0], sd[0], ur[0], rdy[0]}), 32'h01);
    chk("rst_b", 32'({mc[1], sc[1], lr[1], sd[1], ur[1], rdy[1]}), 32'h01);
    li[0] = 32'hA5F0; ri[0] = 32'h0F0F; v[0] = 1;
    li[1] = 32'h81;   ri[1] = $urandom & msk(1); v[1] = 1;
    @(negedge clk); rst = 2'b00;

    phase = 1; repeat (256) tick();   // left-justified framing and padding
    js[0] = 0;
    phase = 2; repeat (256) tick();   // I2S one-bit delay

    phase = 3;                        // one-frame valid gap
    wait_load0(); ur_cnt = 0;
    v[0] = 0; repeat (64) tick();
    v[0] = 1; repeat (192) tick();
    chk("ur_count", 32'(ur_cnt), 32'd1);

    phase = 4;                        // valid arrives exactly on an empty load
    wait_load0();
    v[0] = 0; repeat (63) tick();
    v[0] = 1; li[0] = $urandom & msk(0); ri[0] = $urandom & msk(0);
    tick();
    chk("coinc_ur", 32'(ur[0]), 32'd1);
    chk("coinc_ready", 32'(rdy[0]), 32'd0);
    repeat (128) tick();

    phase = 5;
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        v[d]  = ($urandom % 8) != 0;
        li[d] = $urandom & msk(d);
        ri[d] = $urandom & msk(d);
        if ($urandom % 400 == 0) js[d] = ~js[d];
      end
      tick();
    end

    phase = 6;                        // reset B mid-frame at p=20
    js[1] = 1; v[1] = 0;
    begin
      bit hit = 0;
      for (int i = 0; i < 600 && !hit; i++) begin
        tick();
        if (e_shift[1] && p[1] == 20) hit = 1;
      end
      if (!hit) begin n_chk++; n_fail++; $display("FAIL wait_p20 timeout"); end
    end
    #2 rst[1] = 1'b1;
    #1 chk("rst_mid", 32'({mc[1], sc[1], lr[1], sd[1], ur[1], rdy[1]}), 32'h01);
    mreset(1);
    phase = 7;
    @(negedge clk) rst[1] = 1'b0;
    repeat (240) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
